// File: rtl/on_chip_with_keyboard_pio_button_in_if.sv
// Avalon-MM slave port bundle for the button/mouse input PIO.
// The master drives the bus strobes; the slave returns registered read data and a level IRQ.
interface on_chip_with_keyboard_pio_button_in_if;
  logic [1:0]  address;
  logic        chipselect;
  logic        read_n;
  logic        write_n;
  logic [31:0] writedata;
  logic [31:0] readdata;
  logic        irq;

  modport master (
    output address, chipselect, read_n, write_n, writedata,
    input  readdata, irq
  );

  modport slave (
    input  address, chipselect, read_n, write_n, writedata,
    output readdata, irq
  );
endinterface

// File: rtl/on_chip_with_keyboard_pio_button_in.sv
// Input PIO: per-bit 2-FF sync, debounce filter, edge capture (W1C), IRQ mask and
// registered Avalon-MM read path.
module on_chip_with_keyboard_pio_button_in #(
  parameter int WIDTH           = 4,
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int EDGE_TYPE       = 0
) (
  input  logic                                  clk,
  input  logic                                  reset_n,
  on_chip_with_keyboard_pio_button_in_if.slave  bus,
  input  logic [WIDTH-1:0]                      in_port
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic [WIDTH-1:0] s1, s2;
  logic [WIDTH-1:0] filt, filt_d;
  logic [WIDTH-1:0] rise, fall, ev, clr;
  logic [WIDTH-1:0] irqmask, edgecapture;
  logic [CW-1:0]    cnt [WIDTH];
  logic             wr_en, rd_en;
  logic [31:0]      rd_mux;

  assign wr_en = bus.chipselect & ~bus.write_n;
  assign rd_en = bus.chipselect & ~bus.read_n;

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values, independent of statement order.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      s1 <= '0;
      s2 <= '0;
    end else begin
      s1 <= in_port;
      s2 <= s1;
    end
  end

  // NOTE: the per-bit counter array is a handful of flops, not a RAM, so it is
  // reset along with everything else; mid-debounce reset must discard progress.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      filt <= '0;
      for (int i = 0; i < WIDTH; i++) cnt[i] <= '0;
    end else begin
      for (int i = 0; i < WIDTH; i++) begin
        if (s2[i] == filt[i]) begin
          cnt[i] <= '0;
        end else if (cnt[i] == CNT_LAST) begin
          filt[i] <= s2[i];
          cnt[i]  <= '0;
        end else begin
          cnt[i] <= cnt[i] + CW'(1);
        end
      end
    end
  end

  assign rise = filt & ~filt_d;
  assign fall = ~filt & filt_d;
  assign ev   = (EDGE_TYPE == 0) ? rise :
                (EDGE_TYPE == 1) ? fall : (rise | fall);
  assign clr  = (wr_en && bus.address == 2'd3) ? bus.writedata[WIDTH-1:0] : '0;

  // NOTE: every variable assigned in always_comb gets a default first so no
  // path can leave it unassigned and infer a latch.
  always_comb begin
    rd_mux = '0;
    case (bus.address)
      2'd0:    rd_mux = 32'(filt);
      2'd2:    rd_mux = 32'(irqmask);
      2'd3:    rd_mux = 32'(edgecapture);
      default: rd_mux = '0;
    endcase
  end

  // A new edge overrides a same-cycle clear so no event is ever lost.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      filt_d       <= '0;
      edgecapture  <= '0;
      irqmask      <= '0;
      bus.irq      <= 1'b0;
      bus.readdata <= '0;
    end else begin
      filt_d      <= filt;
      edgecapture <= ev | (edgecapture & ~clr);
      if (wr_en && bus.address == 2'd2) irqmask <= bus.writedata[WIDTH-1:0];
      bus.irq      <= |(edgecapture & irqmask);
      bus.readdata <= rd_en ? rd_mux : '0;
    end
  end

  if (WIDTH < 32) begin : g_unused
    logic unused_wdata;
    assign unused_wdata = ^bus.writedata[31:WIDTH];
  end

endmodule

// File: tb/tb_on_chip_with_keyboard_pio_button_in.sv
// Scoreboard bench for the input PIO: read expectations are queued at issue time and
// checked by a monitor when the registered read data appears.
module tb_on_chip_with_keyboard_pio_button_in;

  logic       clk = 1'b0;
  logic       reset_n;
  logic [3:0] in_port;

  on_chip_with_keyboard_pio_button_in_if bus ();

  on_chip_with_keyboard_pio_button_in #(
    .WIDTH(4), .DEBOUNCE_CYCLES(16), .EDGE_TYPE(0)
  ) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus),
    .in_port (in_port)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic [31:0] data;
    logic        irq;
  } exp_t;

  exp_t sb [$];
  int   n_cmp = 0;
  int   n_bad = 0;
  logic rd_pend = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Monitor: a read strobe sampled at an edge means readdata is valid after it.
  always @(posedge clk) rd_pend <= bus.chipselect && !bus.read_n;

  always @(negedge clk) begin
    if (rd_pend && reset_n) begin
      if (sb.size() == 0) begin
        check("sb_unexpected_read", 32'd1, 32'd0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check({e.name, "_data"}, bus.readdata, e.data);
        check({e.name, "_irq"}, {31'b0, bus.irq}, {31'b0, e.irq});
      end
    end
  end

  task automatic bus_idle();
    bus.chipselect = 1'b0;
    bus.read_n     = 1'b1;
    bus.write_n    = 1'b1;
    bus.address    = 2'd0;
    bus.writedata  = 32'd0;
  endtask

  task automatic bus_read(input logic [1:0] a, input logic [31:0] exp_data,
                          input logic exp_irq, input string name);
    exp_t e;
    @(posedge clk); #1;
    bus.chipselect = 1'b1;
    bus.read_n     = 1'b0;
    bus.address    = a;
    e.name = name;
    e.data = exp_data;
    e.irq  = exp_irq;
    sb.push_back(e);
    @(posedge clk); #1;
    bus_idle();
  endtask

  task automatic bus_write(input logic [1:0] a, input logic [31:0] d);
    @(posedge clk); #1;
    bus.chipselect = 1'b1;
    bus.write_n    = 1'b0;
    bus.address    = a;
    bus.writedata  = d;
    @(posedge clk); #1;
    bus_idle();
  endtask

  // Read and write strobes together: the read sees the pre-write register value.
  task automatic bus_rw(input logic [1:0] a, input logic [31:0] d,
                        input logic [31:0] exp_data, input logic exp_irq, input string name);
    exp_t e;
    @(posedge clk); #1;
    bus.chipselect = 1'b1;
    bus.write_n    = 1'b0;
    bus.read_n     = 1'b0;
    bus.address    = a;
    bus.writedata  = d;
    e.name = name;
    e.data = exp_data;
    e.irq  = exp_irq;
    sb.push_back(e);
    @(posedge clk); #1;
    bus_idle();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    bus_idle();
    in_port = 4'hF;
    reset_n = 1'b0;
    #2;
    check("rst_readdata", bus.readdata, 32'd0);
    check("rst_irq", {31'b0, bus.irq}, 32'd0);
    repeat (4) @(posedge clk);
    #1 reset_n = 1'b1;

    // Inputs held high through reset: the filtered rise appears only after debounce.
    bus_read(2'd0, 32'h0, 1'b0, "t1_data_early");
    bus_read(2'd3, 32'h0, 1'b0, "t1_ec_early");
    repeat (20) @(posedge clk);
    bus_read(2'd0, 32'hF, 1'b0, "t1_data");
    bus_read(2'd3, 32'hF, 1'b0, "t1_ec");
    bus_read(2'd2, 32'h0, 1'b0, "t1_mask");

    // Falling edges are not captured with rising-edge selection.
    in_port = 4'h0;
    repeat (22) @(posedge clk);
    bus_read(2'd3, 32'hF, 1'b0, "t1_ec_after_fall");
    bus_write(2'd3, 32'hF);
    bus_read(2'd3, 32'h0, 1'b0, "t1_ec_cleared");
    bus_read(2'd0, 32'h0, 1'b0, "t1_data_low");

    // Glitch shorter than the debounce window.
    @(posedge clk); #1 in_port[0] = 1'b1;
    repeat (10) @(posedge clk);
    #1 in_port[0] = 1'b0;
    repeat (25) @(posedge clk);
    bus_read(2'd0, 32'h0, 1'b0, "t2_data");
    bus_read(2'd3, 32'h0, 1'b0, "t2_ec");

    // Register map and read/write interactions.
    bus_read(2'd1, 32'h0, 1'b0, "t5_reserved");
    bus_write(2'd2, 32'hFFFF_FFFF);
    bus_read(2'd2, 32'h0000_000F, 1'b0, "t5_mask_all");
    bus_write(2'd0, 32'hFFFF_FFFF);
    bus_read(2'd0, 32'h0, 1'b0, "t5_data_write_ignored");
    bus_write(2'd1, 32'hFFFF_FFFF);
    bus_read(2'd1, 32'h0, 1'b0, "t5_reserved_write_ignored");
    bus_rw(2'd2, 32'h2, 32'h0000_000F, 1'b0, "t5_rw_prewrite");
    bus_read(2'd2, 32'h2, 1'b0, "t5_mask_2");

    // Rising edge on bit 1 with the mask set: irq exactly 20 cycles after the change.
    @(posedge clk); #1 in_port[1] = 1'b1;
    repeat (19) @(posedge clk);
    @(negedge clk);
    check("t3_irq_cycle19", {31'b0, bus.irq}, 32'd0);
    @(negedge clk);
    check("t3_irq_cycle20", {31'b0, bus.irq}, 32'd1);
    bus_read(2'd3, 32'h2, 1'b1, "t3_ec");
    bus_write(2'd3, 32'h2);
    @(negedge clk);
    check("t3_irq_clear_same", {31'b0, bus.irq}, 32'd1);
    @(negedge clk);
    check("t3_irq_clear_next", {31'b0, bus.irq}, 32'd0);
    bus_read(2'd3, 32'h0, 1'b0, "t3_ec_cleared");

    // W1C of bit 2 lands on the same cycle as its rising edge: the edge wins.
    @(posedge clk); #1 in_port[2] = 1'b1;
    repeat (17) @(posedge clk);
    bus_write(2'd3, 32'h4);
    bus_read(2'd3, 32'h4, 1'b0, "t4_ec_edge_wins");
    bus_read(2'd0, 32'h6, 1'b0, "t4_data");

    // Build up edgecapture=5, mask=5, irq=1, then reset asynchronously.
    bus_write(2'd2, 32'h5);
    @(posedge clk); #1 in_port[0] = 1'b1;
    repeat (22) @(posedge clk);
    #1 in_port = 4'h0;
    repeat (22) @(posedge clk);
    bus_read(2'd3, 32'h5, 1'b1, "t6_ec_pre");
    bus_read(2'd2, 32'h5, 1'b1, "t6_mask_pre");

    @(posedge clk); #1;
    bus.chipselect = 1'b1;
    bus.read_n     = 1'b0;
    bus.address    = 2'd3;
    @(posedge clk); #1;
    bus_idle();
    reset_n = 1'b0;
    #1;
    check("t6_async_readdata", bus.readdata, 32'd0);
    check("t6_async_irq", {31'b0, bus.irq}, 32'd0);
    repeat (3) @(posedge clk);
    #1 reset_n = 1'b1;
    bus_read(2'd3, 32'h0, 1'b0, "t6_ec_post");
    bus_read(2'd2, 32'h0, 1'b0, "t6_mask_post");
    repeat (25) @(posedge clk);
    bus_read(2'd3, 32'h0, 1'b0, "t6_ec_settled");
    bus_read(2'd0, 32'h0, 1'b0, "t6_data_settled");

    repeat (3) @(posedge clk);
    check("sb_drained", 32'(sb.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
